exe_stage_md: RTL and testbench

EXE_STAGE_MD -- requirements
Module: exe_stage_md

---
 rtl/exe_pkg.sv | 33 +++
 rtl/alu_param.sv | 37 +++
 rtl/exe_stage_md.sv | 167 ++++++++++++++++
 tb/tb_exe_stage_md.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/exe_pkg.sv
// Shared encodings for the execute stage: opcodes, operand selects and FSM/op-kind types.
package exe_pkg;

    localparam logic [3:0] OP_ADD  = 4'b0000;
    localparam logic [3:0] OP_SUB  = 4'b0010;
    localparam logic [3:0] OP_AND  = 4'b0100;
    localparam logic [3:0] OP_OR   = 4'b0101;
    localparam logic [3:0] OP_NOR  = 4'b0110;
    localparam logic [3:0] OP_XOR  = 4'b0111;
    localparam logic [3:0] OP_SLL  = 4'b1000;
    localparam logic [3:0] OP_SRA  = 4'b1001;
    localparam logic [3:0] OP_SRL  = 4'b1010;
    localparam logic [3:0] OP_MUL  = 4'b1100;
    localparam logic [3:0] OP_DIVU = 4'b1101;
    localparam logic [3:0] OP_REMU = 4'b1110;

    localparam logic [1:0] SEL_VAL  = 2'd0;
    localparam logic [1:0] SEL_MEM  = 2'd1;
    localparam logic [1:0] SEL_WB   = 2'd2;
    localparam logic [1:0] SEL_ZERO = 2'd3;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    typedef enum logic [1:0] {
        MD_MUL  = 2'd0,
        MD_DIVU = 2'd1,
        MD_REMU = 2'd2
    } md_op_t;

endpackage

// File: rtl/alu_param.sv
// Combinational single-cycle ALU; unknown opcodes (including the iterative ones) yield zero.
module alu_param
    import exe_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CMD_W = 4
) (
    input  logic [CMD_W-1:0] i_cmd,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    output logic [WIDTH-1:0] o_y
);
    localparam int SH_W = $clog2(WIDTH);

    logic [SH_W-1:0]         w_sh;
    logic signed [WIDTH-1:0] w_a_s;

    assign w_sh  = i_b[SH_W-1:0];
    assign w_a_s = $signed(i_a);

    always_comb begin
        o_y = '0;
        case (i_cmd)
            CMD_W'(OP_ADD): o_y = i_a + i_b;
            CMD_W'(OP_SUB): o_y = i_a - i_b;
            CMD_W'(OP_AND): o_y = i_a & i_b;
            CMD_W'(OP_OR):  o_y = i_a | i_b;
            CMD_W'(OP_NOR): o_y = ~(i_a | i_b);
            CMD_W'(OP_XOR): o_y = i_a ^ i_b;
            CMD_W'(OP_SLL): o_y = i_a << w_sh;
            CMD_W'(OP_SRA): o_y = $unsigned(w_a_s >>> w_sh);
            CMD_W'(OP_SRL): o_y = i_a >> w_sh;
            default:        o_y = '0;
        endcase
    end

endmodule

// File: rtl/exe_stage_md.sv
// Execute stage with forwarding muxes, 1-cycle ALU ops and WIDTH-cycle iterative MUL/DIVU/REMU.
module exe_stage_md
    import exe_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CMD_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             valid_in,
    input  logic [CMD_W-1:0] exe_cmd,
    input  logic [WIDTH-1:0] val1,
    input  logic [WIDTH-1:0] val2,
    input  logic [WIDTH-1:0] mem_alu_result,
    input  logic [WIDTH-1:0] wb_result,
    input  logic [1:0]       src1_sel,
    input  logic [1:0]       src2_sel,
    output logic             busy,
    output logic [WIDTH-1:0] result,
    output logic             result_valid
);
    localparam int              CNT_W     = $clog2(WIDTH) + 1;
    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

    state_t           r_state;
    md_op_t           r_md_op;
    logic [CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0] r_result;
    logic             r_result_valid;
    // r_a: multiplicand / dividend-quotient shifter; r_b: multiplier / divisor; r_acc: product / remainder
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_acc;

    logic [WIDTH-1:0] w_op1;
    logic [WIDTH-1:0] w_op2;
    logic [WIDTH-1:0] w_alu_y;
    logic             w_is_md;
    md_op_t           w_md_op;
    logic             w_accept_md;
    logic             w_last;
    logic [WIDTH-1:0] w_mul_acc;
    logic [WIDTH:0]   w_div_shift;
    logic [WIDTH:0]   w_div_diff;
    logic             w_div_ge;
    logic [WIDTH-1:0] w_div_rem;
    logic [WIDTH-1:0] w_div_quo;
    logic [WIDTH-1:0] w_md_res;

    always_comb begin
        case (src1_sel)
            SEL_VAL: w_op1 = val1;
            SEL_MEM: w_op1 = mem_alu_result;
            SEL_WB:  w_op1 = wb_result;
            default: w_op1 = '0;
        endcase
        case (src2_sel)
            SEL_VAL: w_op2 = val2;
            SEL_MEM: w_op2 = mem_alu_result;
            SEL_WB:  w_op2 = wb_result;
            default: w_op2 = '0;
        endcase
    end

    always_comb begin
        w_is_md = 1'b1;
        w_md_op = MD_MUL;
        if (exe_cmd == CMD_W'(OP_MUL)) begin
            w_md_op = MD_MUL;
        end else if (exe_cmd == CMD_W'(OP_DIVU)) begin
            w_md_op = MD_DIVU;
        end else if (exe_cmd == CMD_W'(OP_REMU)) begin
            w_md_op = MD_REMU;
        end else begin
            w_is_md = 1'b0;
        end
    end

    alu_param #(
        .WIDTH (WIDTH),
        .CMD_W (CMD_W)
    ) u_alu (
        .i_cmd (exe_cmd),
        .i_a   (w_op1),
        .i_b   (w_op2),
        .o_y   (w_alu_y)
    );

    assign w_accept_md = (r_state == ST_IDLE) && valid_in && w_is_md;
    assign w_last      = (r_cnt == LAST_ITER);

    // One shift-add step and one restoring-divide step; a zero divisor naturally gives all-ones / dividend
    assign w_mul_acc   = r_acc + (r_b[0] ? r_a : '0);
    assign w_div_shift = {r_acc, r_a[WIDTH-1]};
    assign w_div_diff  = w_div_shift - {1'b0, r_b};
    assign w_div_ge    = ~w_div_diff[WIDTH];
    assign w_div_rem   = w_div_ge ? w_div_diff[WIDTH-1:0] : w_div_shift[WIDTH-1:0];
    assign w_div_quo   = {r_a[WIDTH-2:0], w_div_ge};

    always_comb begin
        case (r_md_op)
            MD_MUL:  w_md_res = w_mul_acc;
            MD_DIVU: w_md_res = w_div_quo;
            default: w_md_res = w_div_rem;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state        <= ST_IDLE;
            r_md_op        <= MD_MUL;
            r_cnt          <= '0;
            r_result       <= '0;
            r_result_valid <= 1'b0;
        end else begin
            r_result_valid <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (valid_in) begin
                        if (w_is_md) begin
                            r_state <= ST_RUN;
                            r_md_op <= w_md_op;
                            r_cnt   <= '0;
                        end else begin
                            r_result       <= w_alu_y;
                            r_result_valid <= 1'b1;
                        end
                    end
                end
                ST_RUN: begin
                    if (w_last) begin
                        r_state        <= ST_IDLE;
                        r_cnt          <= '0;
                        r_result       <= w_md_res;
                        r_result_valid <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // Iteration datapath: no reset needed, always loaded at accept before use
    always_ff @(posedge clk) begin
        if (w_accept_md) begin
            r_a   <= w_op1;
            r_b   <= w_op2;
            r_acc <= '0;
        end else if (r_state == ST_RUN) begin
            if (r_md_op == MD_MUL) begin
                r_acc <= w_mul_acc;
                r_a   <= r_a << 1;
                r_b   <= r_b >> 1;
            end else begin
                r_acc <= w_div_rem;
                r_a   <= w_div_quo;
            end
        end
    end

    assign busy         = (r_state == ST_RUN);
    assign result       = r_result;
    assign result_valid = r_result_valid;

endmodule

// File: tb/tb_exe_stage_md.sv
// Directed bench for exe_stage_md: 32-bit instance for ALU/MUL/reset, 8-bit instance for divide.
module tb_exe_stage_md;
    import exe_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst32, vin32, busy32, rv32;
    logic [3:0]  cmd32;
    logic [31:0] v1_32, v2_32, mem32, wb32, res32;
    logic [1:0]  s1_32, s2_32;

    logic        rst8, vin8, busy8, rv8;
    logic [3:0]  cmd8;
    logic [7:0]  v1_8, v2_8, mem8, wb8, res8;
    logic [1:0]  s1_8, s2_8;

    exe_stage_md #(.WIDTH(32), .CMD_W(4)) dut32 (
        .clk(clk), .rst(rst32), .valid_in(vin32), .exe_cmd(cmd32),
        .val1(v1_32), .val2(v2_32), .mem_alu_result(mem32), .wb_result(wb32),
        .src1_sel(s1_32), .src2_sel(s2_32),
        .busy(busy32), .result(res32), .result_valid(rv32)
    );

    exe_stage_md #(.WIDTH(8), .CMD_W(4)) dut8 (
        .clk(clk), .rst(rst8), .valid_in(vin8), .exe_cmd(cmd8),
        .val1(v1_8), .val2(v2_8), .mem_alu_result(mem8), .wb_result(wb8),
        .src1_sel(s1_8), .src2_sel(s2_8),
        .busy(busy8), .result(res8), .result_valid(rv8)
    );

    typedef struct {
        logic [3:0]  cmd;
        logic [31:0] v1;
        logic [31:0] v2;
        logic [31:0] mem;
        logic [31:0] wb;
        logic [1:0]  s1;
        logic [1:0]  s2;
        logic [31:0] exp;
        string       name;
    } vec_t;

    vec_t vecs[14];
    int   n_checks = 0;
    int   n_errors = 0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic md32(input logic [3:0] cmd, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp, input string nm);
        int lat;
        int bcnt;
        lat  = 1;
        bcnt = 0;
        vin32 = 1'b1; cmd32 = cmd; v1_32 = a; v2_32 = b; s1_32 = SEL_VAL; s2_32 = SEL_VAL;
        tick();
        vin32 = 1'b0;
        while (lat < 40 && !rv32) begin
            if (busy32) bcnt++;
            tick();
            lat++;
        end
        chk({nm, " latency"}, 64'(lat), 64'd33);
        chk({nm, " busy cycles"}, 64'(bcnt), 64'd32);
        chk({nm, " result"}, 64'(res32), 64'(exp));
    endtask

    task automatic md8(input logic [3:0] cmd, input logic [7:0] a, input logic [7:0] b,
                       input logic [7:0] exp, input string nm);
        int lat;
        int bcnt;
        lat  = 1;
        bcnt = 0;
        vin8 = 1'b1; cmd8 = cmd; v1_8 = a; v2_8 = b; s1_8 = SEL_VAL; s2_8 = SEL_VAL;
        tick();
        vin8 = 1'b0;
        while (lat < 20 && !rv8) begin
            if (busy8) bcnt++;
            tick();
            lat++;
        end
        chk({nm, " latency"}, 64'(lat), 64'd9);
        chk({nm, " busy cycles"}, 64'(bcnt), 64'd8);
        chk({nm, " result"}, 64'(res8), 64'(exp));
        chk({nm, " busy after"}, 64'(busy8), 64'd0);
    endtask

    initial begin
        int bcnt;
        int early;
        int rvcnt;

        vecs[0]  = '{OP_ADD, 32'd5, 32'd7, 32'd0, 32'd0, SEL_VAL, SEL_VAL, 32'd12, "add"};
        vecs[1]  = '{OP_SUB, 32'd0, 32'd0, 32'd100, 32'd1, SEL_MEM, SEL_WB, 32'd99, "sub_fwd"};
        vecs[2]  = '{OP_ADD, 32'hFFFF_FFFF, 32'd2, 32'd0, 32'd0, SEL_VAL, SEL_VAL, 32'd1, "add_wrap"};
        vecs[3]  = '{OP_SUB, 32'd0, 32'd1, 32'd0, 32'd0, SEL_VAL, SEL_VAL, 32'hFFFF_FFFF, "sub_wrap"};
        vecs[4]  = '{OP_AND, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'd0, 32'd0, SEL_VAL, SEL_VAL, 32'hF000_F000, "and"};
        vecs[5]  = '{OP_OR, 32'h0F0F_0000, 32'h0000_00F0, 32'd0, 32'd0, SEL_VAL, SEL_VAL, 32'h0F0F_00F0, "or"};
        vecs[6]  = '{OP_NOR, 32'hFFFF_0000, 32'h0000_FF00, 32'd0, 32'd0, SEL_VAL, SEL_VAL, 32'h0000_00FF, "nor"};
        vecs[7]  = '{OP_XOR, 32'hAAAA_5555, 32'hFFFF_0000, 32'd0, 32'd0, SEL_VAL, SEL_VAL, 32'h5555_5555, "xor"};
        vecs[8]  = '{OP_SLL, 32'd1, 32'd35, 32'd0, 32'd0, SEL_VAL, SEL_VAL, 32'd8, "sll_low5"};
        vecs[9]  = '{OP_SRA, 32'h8000_0000, 32'd4, 32'd0, 32'd0, SEL_VAL, SEL_VAL, 32'hF800_0000, "sra"};
        vecs[10] = '{OP_SRL, 32'h8000_0000, 32'd4, 32'd0, 32'd0, SEL_VAL, SEL_VAL, 32'h0800_0000, "srl"};
        vecs[11] = '{4'b0011, 32'd9, 32'd9, 32'd0, 32'd0, SEL_VAL, SEL_VAL, 32'd0, "undef_op"};
        vecs[12] = '{OP_ADD, 32'd123, 32'd5, 32'd0, 32'd0, SEL_ZERO, SEL_VAL, 32'd5, "sel_zero"};
        vecs[13] = '{OP_ADD, 32'd0, 32'd0, 32'd2, 32'd40, SEL_WB, SEL_MEM, 32'd42, "sel_wb_mem"};

        rst32 = 1'b1; vin32 = 1'b0; cmd32 = '0; v1_32 = '0; v2_32 = '0; mem32 = '0; wb32 = '0;
        s1_32 = '0; s2_32 = '0;
        rst8 = 1'b1; vin8 = 1'b0; cmd8 = '0; v1_8 = '0; v2_8 = '0; mem8 = '0; wb8 = '0;
        s1_8 = '0; s2_8 = '0;
        tick();
        tick();
        chk("reset busy", 64'(busy32), 64'd0);
        chk("reset result", 64'(res32), 64'd0);
        chk("reset result_valid", 64'(rv32), 64'd0);
        chk("reset8 result", 64'(res8), 64'd0);
        rst32 = 1'b0;
        rst8  = 1'b0;

        // First vector is presented in the first cycle after reset release
        for (int i = 0; i < 14; i++) begin
            vin32 = 1'b1; cmd32 = vecs[i].cmd; v1_32 = vecs[i].v1; v2_32 = vecs[i].v2;
            mem32 = vecs[i].mem; wb32 = vecs[i].wb; s1_32 = vecs[i].s1; s2_32 = vecs[i].s2;
            tick();
            vin32 = 1'b0;
            chk({vecs[i].name, " result"}, 64'(res32), 64'(vecs[i].exp));
            chk({vecs[i].name, " valid"}, 64'(rv32), 64'd1);
            chk({vecs[i].name, " busy"}, 64'(busy32), 64'd0);
        end
        s1_32 = SEL_VAL; s2_32 = SEL_VAL;
        tick();
        chk("hold valid", 64'(rv32), 64'd0);
        chk("hold result", 64'(res32), 64'd42);

        // MUL with an ADD offered mid-run that must be ignored
        vin32 = 1'b1; cmd32 = OP_MUL; v1_32 = 32'h0001_0003; v2_32 = 32'h0001_0002;
        tick();
        bcnt  = 0;
        early = 0;
        for (int c = 1; c <= 32; c++) begin
            if (busy32) bcnt++;
            if (rv32) early++;
            if (c == 10) begin
                vin32 = 1'b1; cmd32 = OP_ADD; v1_32 = 32'd1; v2_32 = 32'd1;
            end else begin
                vin32 = 1'b0;
            end
            tick();
        end
        chk("mul busy cycles", 64'(bcnt), 64'd32);
        chk("mul early valid", 64'(early), 64'd0);
        chk("mul valid c33", 64'(rv32), 64'd1);
        chk("mul busy c33", 64'(busy32), 64'd0);
        chk("mul result", 64'(res32), 64'h0005_0006);

        // ADD back-to-back with the MUL result cycle
        vin32 = 1'b1; cmd32 = OP_ADD; v1_32 = 32'd3; v2_32 = 32'd4;
        tick();
        vin32 = 1'b0;
        chk("b2b add valid", 64'(rv32), 64'd1);
        chk("b2b add result", 64'(res32), 64'd7);
        tick();
        chk("b2b hold valid", 64'(rv32), 64'd0);

        md32(OP_MUL, 32'd12345, 32'd6789, 32'd83810205, "mul32 dec");
        md32(OP_MUL, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd1, "mul32 ones");
        md32(OP_DIVU, 32'd1000, 32'd7, 32'd142, "divu32");
        md32(OP_REMU, 32'd1000, 32'd7, 32'd6, "remu32");

        md8(OP_DIVU, 8'd200, 8'd7, 8'd28, "divu8");
        md8(OP_REMU, 8'd200, 8'd7, 8'd4, "remu8");
        md8(OP_DIVU, 8'd200, 8'd0, 8'hFF, "divu8 by0");
        md8(OP_REMU, 8'd200, 8'd0, 8'd200, "remu8 by0");
        md8(OP_MUL, 8'd15, 8'd20, 8'd44, "mul8 wrap");

        // Reset asserted mid-divide aborts without a later pulse
        vin32 = 1'b1; cmd32 = OP_DIVU; v1_32 = 32'd1000; v2_32 = 32'd3;
        tick();
        vin32 = 1'b0;
        for (int c = 1; c < 5; c++) tick();
        chk("abort busy before rst", 64'(busy32), 64'd1);
        rst32 = 1'b1;
        #1;
        chk("abort busy", 64'(busy32), 64'd0);
        chk("abort result", 64'(res32), 64'd0);
        chk("abort valid", 64'(rv32), 64'd0);
        tick();
        rst32 = 1'b0;
        rvcnt = 0;
        bcnt  = 0;
        for (int c = 0; c < 40; c++) begin
            if (rv32) rvcnt++;
            if (busy32) bcnt++;
            tick();
        end
        chk("abort no valid", 64'(rvcnt), 64'd0);
        chk("abort no busy", 64'(bcnt), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
